// File: rtl/sm_boot_pkg.sv
// sm_boot_pkg: shared definitions for the ROM boot loader.
//   state_t  - loader FSM states
//   ERR_*    - err_code values reported on the sm_boot_ctrl error output
package sm_boot_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    DATA = 3'd3,
    CHK  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_LEN  = 3'd1;
  localparam logic [2:0] ERR_CHK  = 3'd2;
  localparam logic [2:0] ERR_TMO  = 3'd3;

endpackage

// File: rtl/sm_boot_timer.sv
// sm_boot_timer: inter-byte watchdog for the boot loader.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - count while high; held at zero while low
//   clr        - synchronous clear (a byte arrived)
//   expired    - the count reaches TIMEOUT on the coming clock edge
module sm_boot_timer #(
  parameter int TIMEOUT = 1000000,
  parameter int TMR_W   = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  // Flag one count early so the owner's state changes on exactly the edge
  // where TIMEOUT cycles have elapsed since the last clear.
  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/sm_boot_ctrl.sv
// sm_boot_ctrl: loads the instruction ROM from a UART byte stream.
// Frame: len[7:0], len[15:8], len x 4 data bytes (little-endian words),
// then one byte equal to the XOR of all data bytes.
//   clk, rst_n          - clock, asynchronous active-low reset
//   load_req            - load mode level (high = load)
//   rx_valid, rx_byte   - received byte strobe and value
//   rom_wr/addr/wdata   - ROM write port, one strobe per assembled word
//   cpu_rst_n           - CPU reset, held low while loading or after a load
//   busy, done, error   - frame in progress / image OK / load failed
//   err_code            - ERR_NONE, ERR_LEN, ERR_CHK or ERR_TMO
module sm_boot_ctrl
  import sm_boot_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 1000000,
  parameter int TMR_W   = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rom_wr,
  output logic [31:0] rom_addr,
  output logic [31:0] rom_wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] word_q, word_d;
  logic        rom_wr_q, rom_wr_d;
  logic [31:0] rom_addr_q, rom_addr_d;
  logic [31:0] rom_wdata_q, rom_wdata_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [15:0] hdr_len;
  logic        tmr_en, tmo;

  assign hdr_len = {rx_byte, len_q[7:0]};
  assign tmr_en  = (state_q == HDR1) || (state_q == DATA) || (state_q == CHK);

  sm_boot_timer #(
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (tmr_en),
    .clr     (rx_valid),
    .expired (tmo)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    csum_d      = csum_q;
    word_d      = word_q;
    rom_wr_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    err_code_d  = err_code_q;
    done_d      = done_q;

    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d    = HDR0;
          len_d      = '0;
          word_idx_d = '0;
          byte_idx_d = '0;
          csum_d     = '0;
          done_d     = 1'b0;
        end
      end
      HDR0: begin
        if (!load_req) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          len_d[7:0] = rx_byte;
          state_d    = HDR1;
        end
      end
      HDR1: begin
        if (!load_req) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          len_d = hdr_len;
          if (hdr_len > DEPTH_W) begin
            state_d    = ERR;
            err_code_d = ERR_LEN;
          end else if (hdr_len == 16'd0) begin
            state_d = CHK;
          end else begin
            state_d = DATA;
          end
        end else if (tmo) begin
          state_d    = ERR;
          err_code_d = ERR_TMO;
        end
      end
      DATA: begin
        if (!load_req) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          csum_d                          = csum_q ^ rx_byte;
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
          byte_idx_d                      = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Assemble from the live byte so the write leaves on the next edge.
            rom_wr_d    = 1'b1;
            rom_addr_d  = {16'd0, word_idx_q};
            rom_wdata_d = {rx_byte, word_q[23:0]};
            word_idx_d  = word_idx_q + 16'd1;
            if (word_idx_q == len_q - 16'd1) begin
              state_d = CHK;
            end
          end
        end else if (tmo) begin
          state_d    = ERR;
          err_code_d = ERR_TMO;
        end
      end
      CHK: begin
        if (!load_req) begin
          state_d = IDLE;
        end else if (rx_valid) begin
          if (rx_byte == csum_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CHK;
          end
        end else if (tmo) begin
          state_d    = ERR;
          err_code_d = ERR_TMO;
        end
      end
      DONE, ERR: begin
        if (!load_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      err_code_d = ERR_NONE;
    end
    if (state_d == DONE) begin
      done_d = 1'b1;
    end
    error_d     = (state_d == ERR);
    busy_d      = (state_d == HDR0) || (state_d == HDR1) ||
                  (state_d == DATA) || (state_d == CHK);
    // Release the CPU only after a full cycle spent idle with load_req low.
    cpu_rst_n_d = (state_q == IDLE) && !load_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_idx_q  <= '0;
      csum_q      <= '0;
      word_q      <= '0;
      rom_wr_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      csum_q      <= csum_d;
      word_q      <= word_d;
      rom_wr_q    <= rom_wr_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign rom_wr    = rom_wr_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_sm_boot_ctrl.sv
// tb_sm_boot_ctrl: directed frames against a frame-level reference model,
// compared every cycle, plus hand-computed literal expectations.
module tb_sm_boot_ctrl;

  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 50;
  localparam int TMR_W   = 8;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_req = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rom_wr;
  logic [31:0] rom_addr;
  logic [31:0] rom_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  err_code;

  sm_boot_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .TMR_W   (TMR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_req  (load_req),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .rom_wr    (rom_wr),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] wr_log[$];

  task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: tracks the frame by byte position and derives the
  // registered outputs from the framing rules.
  typedef enum {P_IDLE, P_FRAME, P_DONE, P_ERR} phase_t;
  phase_t      ph = P_IDLE;
  int          m_nb = 0, m_len = 0, m_quiet = 0;
  logic [7:0]  m_csum = 8'h00;
  logic [31:0] m_word = 32'h0;
  logic        e_wr = 1'b0, e_cpu = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0;
  logic [2:0]  e_code = 3'd0;

  task automatic m_fail(input logic [2:0] c);
    ph = P_ERR; e_err = 1'b1; e_code = c;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ph = P_IDLE; e_wr = 0; e_addr = 0; e_wdata = 0; e_cpu = 0;
      e_busy = 0; e_done = 0; e_err = 0; e_code = 0;
    end else begin
      e_wr = 1'b0;
      case (ph)
        P_IDLE: begin
          e_cpu = !load_req;
          if (load_req) begin
            ph = P_FRAME; m_nb = 0; m_len = 0; m_quiet = 0; m_csum = 0; e_done = 0;
          end
        end
        P_FRAME: begin
          e_cpu = 1'b0;
          if (!load_req) ph = P_IDLE;
          else if (rx_valid) begin
            m_quiet = 0;
            if (m_nb == 0) m_len = int'(rx_byte);
            else if (m_nb == 1) begin
              m_len = m_len + 256 * int'(rx_byte);
              if (m_len > DEPTH) m_fail(3'd1);
            end else if (m_nb < 2 + 4 * m_len) begin
              int i;
              i = m_nb - 2;
              m_word[8*(i%4) +: 8] = rx_byte;
              m_csum = m_csum ^ rx_byte;
              if (i % 4 == 3) begin
                e_wr = 1'b1; e_addr = 32'(i / 4); e_wdata = m_word;
              end
            end else if (rx_byte == m_csum) begin
              ph = P_DONE; e_done = 1'b1;
            end else m_fail(3'd2);
            m_nb++;
          end else if (m_nb >= 1) begin
            m_quiet++;
            if (m_quiet == TIMEOUT) m_fail(3'd3);
          end
        end
        default: begin
          e_cpu = 1'b0;
          if (!load_req) begin
            ph = P_IDLE; e_err = 1'b0; e_code = 3'd0;
          end
        end
      endcase
      e_busy = (ph == P_FRAME);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rom_wr) wr_log.push_back({rom_addr, rom_wdata});
    check("cycle", {7'd0, rom_wr, rom_addr, rom_wdata, cpu_rst_n, busy, done, error, err_code},
                   {7'd0, e_wr, e_addr, e_wdata, e_cpu, e_busy, e_done, e_err, e_code});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_byte = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic send_list(input bq_t bs);
    foreach (bs[i]) send(bs[i]);
  endtask

  task automatic start();
    wr_log.delete();
    @(negedge clk); load_req = 1'b1;
    idle(2);
  endtask

  task automatic stop();
    @(negedge clk); load_req = 1'b0;
    idle(3);
  endtask

  task automatic check_wr(input string nm, input int idx, input logic [63:0] exp);
    logic [63:0] got;
    got = (idx < wr_log.size()) ? wr_log[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
    check(nm, 80'(got), 80'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run, expected $finish");
    $fatal(1);
  end

  initial begin
    bq_t normal, badck;
    int  k;
    normal = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    badck  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};

    // Reset values
    #1 rst_n = 1'b0;
    #2 check("reset_outputs", 80'({rom_wr, rom_addr, rom_wdata, cpu_rst_n, busy, done, error, err_code}), 80'(0));
    idle(3);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("cpu_release_after_reset", 80'(cpu_rst_n), 80'(1));
    idle(2);

    // Normal two-word image
    start();
    check("cpu_held_in_load", 80'(cpu_rst_n), 80'(0));
    send_list(normal);
    idle(3);
    check("normal_done", 80'({done, error, busy, cpu_rst_n}), 80'(4'b1000));
    check("normal_nwr", 80'(wr_log.size()), 80'(2));
    check_wr("normal_wr0", 0, {32'd0, 32'h0000_0013});
    check_wr("normal_wr1", 1, {32'd1, 32'h0010_0093});
    send(8'h55);
    idle(2);
    check("done_ignores_rx", 80'({done, error, err_code}), 80'(5'b10000));
    @(negedge clk); load_req = 1'b0;
    @(posedge clk); #1;
    check("cpu_still_held", 80'(cpu_rst_n), 80'(0));
    @(posedge clk); #1;
    check("cpu_released", 80'(cpu_rst_n), 80'(1));
    idle(2);

    // Oversize header
    start();
    send_list('{8'h41, 8'h00});
    idle(2);
    check("len_err", 80'({error, err_code, busy}), 80'(5'b1_001_0));
    check("len_nwr", 80'(wr_log.size()), 80'(0));
    stop();
    check("len_err_cleared", 80'({error, err_code}), 80'(0));

    // Bad checksum
    start();
    send_list(badck);
    idle(2);
    check("chk_err", 80'({done, error, err_code}), 80'(5'b0_1_010));
    check("chk_nwr", 80'(wr_log.size()), 80'(2));
    check_wr("chk_wr1", 1, {32'd1, 32'h0010_0093});
    stop();

    // Inter-byte timeout
    start();
    send_list('{8'h02, 8'h00, 8'h13});
    k = 0;
    for (int j = 1; j <= 120 && k == 0; j++) begin
      @(posedge clk); #1;
      if (error) k = j;
    end
    check("tmo_latency", 80'(k), 80'(TIMEOUT));
    check("tmo_code", 80'(err_code), 80'(3));
    stop();

    // Empty image
    start();
    send_list('{8'h00, 8'h00, 8'h00});
    idle(2);
    check("empty_done", 80'({done, error}), 80'(2'b10));
    check("empty_nwr", 80'(wr_log.size()), 80'(0));
    stop();

    // Abort after the first word
    start();
    send_list('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00});
    load_req = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", 80'({busy, cpu_rst_n}), 80'(0));
    @(posedge clk); #1;
    check("abort_cpu_release", 80'(cpu_rst_n), 80'(1));
    idle(4);
    check("abort_nwr", 80'(wr_log.size()), 80'(1));
    check_wr("abort_wr0", 0, {32'd0, 32'h0000_0013});

    // Asynchronous reset mid-DATA
    start();
    send_list('{8'h02, 8'h00, 8'h13});
    @(negedge clk);
    check("busy_before_rst", 80'(busy), 80'(1));
    #2 rst_n = 1'b0;
    #1 check("async_reset", 80'({rom_wr, rom_addr, rom_wdata, cpu_rst_n, busy, done, error, err_code}), 80'(0));
    @(negedge clk); load_req = 1'b0; rst_n = 1'b1;
    idle(2);
    check("cpu_after_async_rst", 80'(cpu_rst_n), 80'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
